// File: rtl/mic1_mem_unit.sv
// MIC-1 memory responder: MAR-addressed word reads/writes and PC-addressed byte
// fetches against one shared word array, each through a fixed-latency in-order pipeline.
module mic1_mem_unit #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       mar,
    input  logic [31:0]       mdr,
    input  logic [31:0]       pc,
    input  logic              rd,
    input  logic              wr,
    input  logic              fetch,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       ram_data,
    output logic              ram_valid,
    output logic [31:0]       rom_data,
    output logic              rom_valid,
    output logic              busy,
    output logic              err
);
    // Requests have no ready: every rd/wr/fetch sampled high is accepted that cycle,
    // and its result appears exactly LATENCY cycles later as a one-cycle valid pulse.
    localparam int SD = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [SD-1:0]     r_d_vld;
    logic [SD-1:0]     r_d_wr;
    logic [ADDR_W-1:0] r_d_addr [SD];
    logic [31:0]       r_d_dat  [SD];
    logic [SD-1:0]     r_f_vld;
    logic [ADDR_W-1:0] r_f_addr [SD];
    logic [1:0]        r_f_lane [SD];
    logic [31:0]       r_mem    [2**ADDR_W];

    logic              w_d_req;
    logic              w_hd_vld;
    logic              w_hd_wr;
    logic [ADDR_W-1:0] w_hd_addr;
    logic [31:0]       w_hd_dat;
    logic              w_fh_vld;
    logic [ADDR_W-1:0] w_fh_addr;
    logic [1:0]        w_fh_lane;
    logic [31:0]       w_fh_word;
    logic              w_load_ok;
    logic              w_unused;

    assign w_d_req   = rd | wr;
    assign w_load_ok = load_en & ~busy & ~rd & ~wr & ~fetch;
    assign w_fh_word = r_mem[w_fh_addr];
    assign w_unused  = &{1'b0, mar[31:ADDR_W], pc[31:ADDR_W+2]};

    // The "head" is the request that touches the array at the coming edge.
    if (LATENCY == 1) begin : g_direct
        assign w_hd_vld  = w_d_req;
        assign w_hd_wr   = wr;
        assign w_hd_addr = mar[ADDR_W-1:0];
        assign w_hd_dat  = mdr;
        assign w_fh_vld  = fetch;
        assign w_fh_addr = pc[ADDR_W+1:2];
        assign w_fh_lane = pc[1:0];
        assign busy      = 1'b0;
    end else begin : g_piped
        assign w_hd_vld  = r_d_vld[SD-1];
        assign w_hd_wr   = r_d_wr[SD-1];
        assign w_hd_addr = r_d_addr[SD-1];
        assign w_hd_dat  = r_d_dat[SD-1];
        assign w_fh_vld  = r_f_vld[SD-1];
        assign w_fh_addr = r_f_addr[SD-1];
        assign w_fh_lane = r_f_lane[SD-1];
        assign busy      = (|r_d_vld) | (|r_f_vld);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_vld <= '0;
            r_f_vld <= '0;
        end else begin
            for (int i = SD - 1; i > 0; i--) begin
                r_d_vld[i] <= r_d_vld[i-1];
                r_f_vld[i] <= r_f_vld[i-1];
            end
            r_d_vld[0] <= w_d_req;
            r_f_vld[0] <= fetch;
        end
    end

    // Payload needs no reset: it is only ever consumed alongside its valid bit.
    always_ff @(posedge clock) begin
        for (int i = SD - 1; i > 0; i--) begin
            r_d_wr[i]   <= r_d_wr[i-1];
            r_d_addr[i] <= r_d_addr[i-1];
            r_d_dat[i]  <= r_d_dat[i-1];
            r_f_addr[i] <= r_f_addr[i-1];
            r_f_lane[i] <= r_f_lane[i-1];
        end
        r_d_wr[0]   <= wr;
        r_d_addr[0] <= mar[ADDR_W-1:0];
        r_d_dat[0]  <= mdr;
        r_f_addr[0] <= pc[ADDR_W+1:2];
        r_f_lane[0] <= pc[1:0];
    end

    // Load only happens while nothing is in flight, so it never collides with a head write.
    always_ff @(posedge clock) begin
        if (w_hd_vld && w_hd_wr) begin
            r_mem[w_hd_addr] <= w_hd_dat;
        end else if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_data  <= '0;
            ram_valid <= 1'b0;
            rom_data  <= '0;
            rom_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_valid <= w_hd_vld & ~w_hd_wr;
            if (w_hd_vld && !w_hd_wr) begin
                ram_data <= r_mem[w_hd_addr];
            end
            rom_valid <= w_fh_vld;
            if (w_fh_vld) begin
                rom_data <= {24'b0, w_fh_word[{w_fh_lane, 3'b000} +: 8]};
            end
            err <= (rd & wr) | (load_en & ~w_load_ok);
        end
    end
endmodule

// File: tb/tb_mic1_mem_unit.sv
// Directed bench for mic1_mem_unit (ADDR_W=10, LATENCY=2): inputs change 1ns after
// the rising edge, outputs are sampled on the falling edge of the same cycle.
module tb_mic1_mem_unit;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] mar, mdr, pc, load_data;
    logic        rd, wr, fetch, load_en;
    logic [9:0]  load_addr;
    logic [31:0] ram_data, rom_data;
    logic        ram_valid, rom_valid, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    mic1_mem_unit #(.ADDR_W(10), .LATENCY(2)) dut (
        .clock(clock), .reset_n(reset_n), .mar(mar), .mdr(mdr), .pc(pc),
        .rd(rd), .wr(wr), .fetch(fetch), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data),
        .ram_data(ram_data), .ram_valid(ram_valid), .rom_data(rom_data),
        .rom_valid(rom_valid), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        rd = 0; wr = 0; fetch = 0; load_en = 0;
    endtask

    task automatic drain();
        clear_inputs();
        repeat (4) step();
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        step();
        clear_inputs();
        load_en = 1; load_addr = a; load_data = d;
        step();
        load_en = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        clear_inputs();
        mar = 0; mdr = 0; pc = 0; load_addr = 0; load_data = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++; if (ram_data !== 32'h0) begin n_fail++; $display("FAIL reset_ram_data: got %h want 0", ram_data); end
        n_checks++; if (rom_data !== 32'h0) begin n_fail++; $display("FAIL reset_rom_data: got %h want 0", rom_data); end
        n_checks++; if ({ram_valid, rom_valid, busy, err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {ram_valid, rom_valid, busy, err}); end
        step();
        reset_n = 1;
    endtask

    task automatic test_read();
        load_word(10'd5, 32'hCAFEBABE);
        rd = 1; mar = 32'd5;
        @(negedge clock);
        n_checks++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL read_c0_valid: got %b want 0", ram_valid); end
        step(); rd = 0;
        @(negedge clock);
        n_checks++; if ({ram_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL read_c1_valid_busy: got %b want 01", {ram_valid, busy}); end
        step();
        @(negedge clock);
        n_checks++; if ({ram_valid, busy} !== 2'b10) begin n_fail++; $display("FAIL read_c2_valid_busy: got %b want 10", {ram_valid, busy}); end
        n_checks++; if (ram_data !== 32'hCAFEBABE) begin n_fail++; $display("FAIL read_c2_data: got %h want cafebabe", ram_data); end
        step();
        @(negedge clock);
        n_checks++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL read_c3_valid: got %b want 0", ram_valid); end
        n_checks++; if (ram_data !== 32'hCAFEBABE) begin n_fail++; $display("FAIL read_c3_hold: got %h want cafebabe", ram_data); end
        drain();
    endtask

    task automatic test_raw();
        step();
        wr = 1; mar = 32'd3; mdr = 32'h12345678;
        step(); wr = 0; rd = 1; mar = 32'd3;
        step(); rd = 0;
        @(negedge clock);
        n_checks++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL raw_write_no_valid: got %b want 0", ram_valid); end
        step();
        @(negedge clock);
        n_checks++; if (ram_valid !== 1'b1) begin n_fail++; $display("FAIL raw_c3_valid: got %b want 1", ram_valid); end
        n_checks++; if (ram_data !== 32'h12345678) begin n_fail++; $display("FAIL raw_c3_data: got %h want 12345678", ram_data); end
        drain();
    endtask

    task automatic test_fetch();
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load_word(10'd0, 32'hDDCCBBAA);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            fetch = (i < 4); pc = i;
            @(negedge clock);
            if (i >= 2) begin
                n_checks++; if (rom_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid c%0d: got %b want 1", i, rom_valid); end
                n_checks++; if (rom_data !== {24'b0, exp_b[i-2]}) begin
                    n_fail++; $display("FAIL fetch_byte c%0d: got %h want %h", i, rom_data, exp_b[i-2]); end
            end else begin
                n_checks++; if (rom_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early c%0d: got %b want 0", i, rom_valid); end
            end
        end
        drain();
    endtask

    task automatic test_err();
        load_word(10'd7, 32'h0);
        rd = 1; wr = 1; mar = 32'd7; mdr = 32'd1;
        step(); rd = 0; wr = 0;
        @(negedge clock);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rdwr_err: got %b want 1", err); end
        step();
        @(negedge clock);
        n_checks++; if ({ram_valid, err} !== 2'b00) begin n_fail++; $display("FAIL rdwr_no_valid: got %b want 00", {ram_valid, err}); end
        step(); rd = 1; mar = 32'd7;
        step(); rd = 0;
        step();
        @(negedge clock);
        n_checks++; if ({ram_valid, ram_data} !== {1'b1, 32'd1}) begin
            n_fail++; $display("FAIL rdwr_write_kept: got %b/%h want 1/00000001", ram_valid, ram_data); end
        drain();
        load_word(10'd9, 32'h99);
        rd = 1; mar = 32'd9;
        step(); rd = 0; load_en = 1; load_addr = 10'd9; load_data = 32'hBAD;
        @(negedge clock);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_flag: got %b want 1", busy); end
        step(); load_en = 0;
        @(negedge clock);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL load_busy_err: got %b want 1", err); end
        step(); rd = 1; mar = 32'd9;
        step(); rd = 0;
        step();
        @(negedge clock);
        n_checks++; if ({ram_valid, ram_data} !== {1'b1, 32'h99}) begin
            n_fail++; $display("FAIL load_busy_unchanged: got %b/%h want 1/00000099", ram_valid, ram_data); end
        step(); fetch = 1; pc = 32'h24; load_en = 1; load_addr = 10'd9; load_data = 32'hBAD;
        step(); fetch = 0; load_en = 0;
        @(negedge clock);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL load_fetch_err: got %b want 1", err); end
        drain();
    endtask

    task automatic test_wrap();
        load_word(10'd5, 32'h55);
        rd = 1; mar = 32'h405;
        step(); rd = 0;
        step();
        @(negedge clock);
        n_checks++; if ({ram_valid, ram_data} !== {1'b1, 32'h55}) begin
            n_fail++; $display("FAIL wrap_read: got %b/%h want 1/00000055", ram_valid, ram_data); end
        step(); wr = 1; mar = 32'h405; mdr = 32'hA1B2C3D4;
        step(); wr = 0; rd = 1; mar = 32'd5;
        step(); rd = 0;
        step();
        @(negedge clock);
        n_checks++; if ({ram_valid, ram_data} !== {1'b1, 32'hA1B2C3D4}) begin
            n_fail++; $display("FAIL wrap_write: got %b/%h want 1/a1b2c3d4", ram_valid, ram_data); end
        step(); wr = 1; mar = 32'd5; mdr = 32'h11223344; fetch = 1; pc = 32'h14;
        step(); wr = 0; fetch = 0;
        step();
        @(negedge clock);
        n_checks++; if ({rom_valid, rom_data} !== {1'b1, 32'hD4}) begin
            n_fail++; $display("FAIL fetch_before_write: got %b/%h want 1/000000d4", rom_valid, rom_data); end
        step(); fetch = 1; pc = 32'h1017;
        step(); fetch = 0;
        step();
        @(negedge clock);
        n_checks++; if ({rom_valid, rom_data} !== {1'b1, 32'h11}) begin
            n_fail++; $display("FAIL fetch_wrap_lane3: got %b/%h want 1/00000011", rom_valid, rom_data); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = 32'hA0B0C0D0;
        for (int j = 0; j < 4; j++) load_word(10'(10 + j), base + j);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            rd = (i < 4); fetch = (i < 4); mar = 10 + i; pc = 32'h28 + i;
            @(negedge clock);
            n_checks++; if (busy !== (i >= 1 && i <= 4)) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b", i, busy); end
            if (i >= 2) begin
                n_checks++; if ({ram_valid, ram_data} !== {1'b1, base + (i - 2)}) begin
                    n_fail++; $display("FAIL b2b_ram c%0d: got %b/%h want 1/%h", i, ram_valid, ram_data, base + (i - 2)); end
                n_checks++; if ({rom_valid, rom_data} !== {1'b1, (base >> (8 * (i - 2))) & 32'hFF}) begin
                    n_fail++; $display("FAIL b2b_rom c%0d: got %b/%h want 1/%h", i, rom_valid, rom_data, (base >> (8 * (i - 2))) & 32'hFF); end
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        for (int op = 0; op < 2; op++) begin
            load_word(10'd20, 32'h20202020);
            rd = (op == 0); wr = (op == 1); mar = 32'd20; mdr = 32'hDEAD;
            step(); clear_inputs(); reset_n = 0;
            @(negedge clock);
            n_checks++; if ({ram_data, rom_data} !== 64'h0) begin
                n_fail++; $display("FAIL midreset_data op%0d: got %h/%h want 0/0", op, ram_data, rom_data); end
            n_checks++; if ({ram_valid, rom_valid, busy, err} !== 4'b0000) begin
                n_fail++; $display("FAIL midreset_flags op%0d: got %b want 0000", op, {ram_valid, rom_valid, busy, err}); end
            step(); step(); reset_n = 1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                n_checks++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_valid op%0d c%0d: got 1 want 0", op, c); end
                step();
            end
            rd = 1; mar = 32'd20;
            step(); rd = 0;
            step();
            @(negedge clock);
            n_checks++; if ({ram_valid, ram_data} !== {1'b1, 32'h20202020}) begin
                n_fail++; $display("FAIL midreset_word op%0d: got %b/%h want 1/20202020", op, ram_valid, ram_data); end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_raw();
        test_fetch();
        test_err();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
